prbs_gen_par: RTL and testbench
===============================

// Module: prbs_gen_par
// PURPOSE
//  Parametrised parallel PRBS generator, successor to the fixed 4-bit CRBS LFSR.
//  Produces OUT_W bits per transfer from a runtime-selectable PRBS7/9/15/23/31 Fibonacci LFSR.
//  Supports seed load, enable/halt and a valid/ready output handshake.
//  Feeds serialiser/BERT test paths on the FPGA.
// PARAMETERS
//  OUT_W     4      bits per output word, 1..32
//  SEED_DEF  31'h7FFFFFFF  reset seed; masked to the active order
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active-low
//  en         in   1      1 = run; 0 = halt after the current word drains
//  mode       in   3      0=PRBS7 1=PRBS9 2=PRBS15 3=PRBS23 4=PRBS31; 5..7 map to PRBS7
//  load       in   1      1-cycle pulse: latch mode and seed, restart sequence
//  seed       in   31     seed value; low ORDER bits used
//  out_data   out  OUT_W  PRBS word; first-generated bit in MSB
//  out_valid  out  1      out_data holds a valid word
//  out_ready  in   1      consumer accepts the word when out_valid & out_ready
//  err_inj    in   1      error-inject request (used only with PRBS_ERR_INJ_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): lfsr=SEED_DEF masked, mode_q=PRBS7, out_data=0, out_valid=0, FSM=IDLE.
//  - LFSR step: b = s[TA-1]^s[TB-1]; s <= {s[ORDER-2:0], b}; output bit = b.
//    Taps (TA,TB): PRBS7 (7,6), PRBS9 (9,5), PRBS15 (15,14), PRBS23 (23,18), PRBS31 (31,28).
//  - One word = OUT_W consecutive steps, computed combinationally; the word is produced in 1 clk.
//  - FSM: IDLE -> (en) FILL -> RUN; RUN -> (!en & transfer, or !en & !out_valid) -> IDLE.
//    FILL: load first word into out_data, out_valid<=1; latency en-to-valid = 2 clk.
//    RUN: on transfer with en=1, next word is loaded the same edge (back-to-back, 1 word/clk).
//    Stall (valid & !ready): out_data and lfsr held, must not change.
//  - out_valid never drops without a transfer, except on load or reset.
//  - load: highest priority after reset. mode_q<=mode, lfsr<=seed masked, out_valid<=0,
//    FSM->FILL if en else IDLE. A pending unaccepted word is discarded.
//  - All-zero masked seed (lockup) is replaced by all-ones.
//  - mode changes without load are ignored; mode_q only updates on load.
//  - Simultaneous load and transfer: the transfer completes for the consumer, and load wins internally.
//  - Period: (2^ORDER-1) words when gcd(OUT_W, 2^ORDER-1)=1.
// CONFIGURATION
//  PRBS_ERR_INJ_EN defined: err_inj pulse arms a flag. The next word loaded into out_data
//    has bit OUT_W-1 inverted and the flag clears. lfsr itself is never corrupted.
//  PRBS_ERR_INJ_EN undefined: err_inj is ignored, no flag register exists, and output is pure PRBS.
// STRUCTURE
//  - Package prbs_pkg: mode encodings (PRBS7..PRBS31), ORDER and tap tables per mode,
//    and typedef of the 31-bit lfsr state.
//  - Sub-module prbs_lfsr_step: combinational OUT_W-step advance.
//    Inputs are state and mode; outputs are next state and word.
//  - Top holds the FSM, handshake regs and the inject flag.
// TESTING
//  1. Reset, load mode=0 seed=7'h7F, en=1, ready=1, OUT_W=4: words 4'b0000, 4'b0010, ...
//     Word 127 equals word 0.
//  2. Hold ready=0 for 10 clk mid-run: out_data and out_valid stable; stream resumes with no skip.
//  3. Load seed=0 in PRBS15: sequence identical to seed=15'h7FFF.
//  4. Assert load while valid & !ready: old word is dropped.
//     Two clk later, out_valid=1 with the first word of the new seed.
//  5. Deassert en in RUN: one pending word transfers, then out_valid=0 and FSM=IDLE.
//     Re-enable continues the sequence.
//  6. With PRBS_ERR_INJ_EN: pulse err_inj on PRBS31, compare against the reference model.
//     Exactly one word has MSB flipped and later words are error-free.
//     Without the macro, there are no mismatches.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: mode encodings, per-mode order mask, feedback taps and
// the 31-bit LFSR state type.
package prbs_pkg;

  localparam int unsigned LfsrW = 31;

  typedef logic [LfsrW-1:0] lfsr_t;

  typedef enum logic [2:0] {
    ModePrbs7  = 3'd0,
    ModePrbs9  = 3'd1,
    ModePrbs15 = 3'd2,
    ModePrbs23 = 3'd3,
    ModePrbs31 = 3'd4
  } prbs_mode_e;

  // Unused encodings 5..7 fall back to PRBS7.
  function automatic prbs_mode_e mode_decode(logic [2:0] m);
    case (m)
      3'd1:    return ModePrbs9;
      3'd2:    return ModePrbs15;
      3'd3:    return ModePrbs23;
      3'd4:    return ModePrbs31;
      default: return ModePrbs7;
    endcase
  endfunction

  function automatic lfsr_t order_mask(prbs_mode_e m);
    case (m)
      ModePrbs9:  return 31'h0000_01FF;
      ModePrbs15: return 31'h0000_7FFF;
      ModePrbs23: return 31'h007F_FFFF;
      ModePrbs31: return 31'h7FFF_FFFF;
      default:    return 31'h0000_007F;
    endcase
  endfunction

  // Feedback bit s[TA-1] ^ s[TB-1] for the selected polynomial.
  function automatic logic feedback(lfsr_t s, prbs_mode_e m);
    case (m)
      ModePrbs9:  return s[8] ^ s[4];
      ModePrbs15: return s[14] ^ s[13];
      ModePrbs23: return s[22] ^ s[17];
      ModePrbs31: return s[30] ^ s[27];
      default:    return s[6] ^ s[5];
    endcase
  endfunction

  // Mask the seed to the active order; an all-zero result would lock the LFSR.
  function automatic lfsr_t seed_fix(lfsr_t seed, prbs_mode_e m);
    lfsr_t s;
    s = seed & order_mask(m);
    if (s == '0) s = order_mask(m);
    return s;
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational OUT_W-step advance of the Fibonacci LFSR; first generated bit lands in the MSB.
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int unsigned OUT_W = 4
) (
  input  lfsr_t            i_state,
  input  prbs_mode_e       i_mode,
  output lfsr_t            o_state,
  output logic [OUT_W-1:0] o_word
);

  lfsr_t w_mask;
  lfsr_t w_chain [OUT_W+1];

  assign w_mask     = order_mask(i_mode);
  assign w_chain[0] = i_state;
  assign o_state    = w_chain[OUT_W];

  for (genvar k = 0; k < OUT_W; k++) begin : g_step
    logic w_bit;
    assign w_bit            = feedback(w_chain[k], i_mode);
    assign w_chain[k+1]     = {w_chain[k][LfsrW-2:0], w_bit} & w_mask;
    assign o_word[OUT_W-1-k] = w_bit;
  end

endmodule

// File: rtl/prbs_gen_par.sv
// Parallel PRBS generator with seed load, enable/halt and valid/ready output.
// Optional PRBS_ERR_INJ_EN: err_inj flips the MSB of the next word loaded.
module prbs_gen_par
  import prbs_pkg::*;
#(
  parameter int unsigned OUT_W    = 4,
  parameter logic [30:0] SEED_DEF = 31'h7FFFFFFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic             i_load,
  input  logic [30:0]      i_seed,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  input  logic             i_err_inj
);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e           r_state, w_state_nxt;
  prbs_mode_e       r_mode, w_mode_nxt, w_load_mode;
  lfsr_t            r_lfsr, w_lfsr_nxt, w_lfsr_step;
  logic [OUT_W-1:0] r_data, w_data_nxt, w_word;
  logic             r_valid, w_valid_nxt;
  logic             w_xfer, w_take;

  prbs_lfsr_step #(
    .OUT_W (OUT_W)
  ) u_step (
    .i_state (r_lfsr),
    .i_mode  (r_mode),
    .o_state (w_lfsr_step),
    .o_word  (w_word)
  );

  assign w_xfer      = r_valid & i_out_ready;
  assign w_load_mode = mode_decode(i_mode);

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_lfsr_nxt  = r_lfsr;
    w_valid_nxt = r_valid;
    w_take      = 1'b0;
    if (i_load) begin
      w_mode_nxt  = w_load_mode;
      w_lfsr_nxt  = seed_fix(i_seed, w_load_mode);
      w_valid_nxt = 1'b0;
      w_state_nxt = i_en ? StFill : StIdle;
    end else begin
      case (r_state)
        StIdle: if (i_en) w_state_nxt = StFill;
        StFill: begin
          w_take      = 1'b1;
          w_state_nxt = StRun;
        end
        StRun: begin
          if (!r_valid || w_xfer) begin
            if (i_en) begin
              w_take = 1'b1;
            end else begin
              w_valid_nxt = 1'b0;
              w_state_nxt = StIdle;
            end
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
    if (w_take) begin
      w_lfsr_nxt  = w_lfsr_step;
      w_valid_nxt = 1'b1;
    end
  end

`ifdef PRBS_ERR_INJ_EN
  logic r_err_flag, w_err_flag_nxt;

  // The LFSR stays clean; only the emitted word carries the error.
  always_comb begin
    w_data_nxt     = r_data;
    w_err_flag_nxt = (r_err_flag & ~w_take) | i_err_inj;
    if (w_take) begin
      w_data_nxt          = w_word;
      w_data_nxt[OUT_W-1] = w_word[OUT_W-1] ^ r_err_flag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_err_flag <= 1'b0;
    else          r_err_flag <= w_err_flag_nxt;
  end
`else
  logic w_unused_err_inj;
  assign w_unused_err_inj = i_err_inj;

  always_comb begin
    w_data_nxt = r_data;
    if (w_take) w_data_nxt = w_word;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_mode  <= ModePrbs7;
      r_lfsr  <= seed_fix(SEED_DEF, ModePrbs7);
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;

endmodule

// File: tb/tb_prbs_gen_par.sv
// Directed bench for prbs_gen_par (OUT_W=4) with hand-computed anchors and a small PRBS model.
module tb_prbs_gen_par;

  localparam int unsigned OUT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, en, load, out_ready, err_inj, out_valid;
  logic [2:0]       mode;
  logic [30:0]      seed;
  logic [OUT_W-1:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [30:0] m_s, m_mask;
  logic [2:0]  m_mode;
  logic [3:0]  exp_w, flip_w;

  always #5 clk = ~clk;

  prbs_gen_par #(
    .OUT_W    (OUT_W),
    .SEED_DEF (31'h7FFFFFFF)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_mode      (mode),
    .i_load      (load),
    .i_seed      (seed),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .i_err_inj   (err_inj)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_load(input logic [2:0] md, input logic [30:0] sd);
    m_mode = (md > 3'd4) ? 3'd0 : md;
    case (m_mode)
      3'd0:    m_mask = 31'h7F;
      3'd1:    m_mask = 31'h1FF;
      3'd2:    m_mask = 31'h7FFF;
      3'd3:    m_mask = 31'h7FFFFF;
      default: m_mask = 31'h7FFFFFFF;
    endcase
    m_s = sd & m_mask;
    if (m_s == '0) m_s = m_mask;
  endtask

  task automatic ref_word(output logic [3:0] w);
    logic b;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      case (m_mode)
        3'd0:    b = m_s[6] ^ m_s[5];
        3'd1:    b = m_s[8] ^ m_s[4];
        3'd2:    b = m_s[14] ^ m_s[13];
        3'd3:    b = m_s[22] ^ m_s[17];
        default: b = m_s[30] ^ m_s[27];
      endcase
      w   = {w[2:0], b};
      m_s = {m_s[29:0], b} & m_mask;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 3'd0; seed = '0;
    out_ready = 1'b0; err_inj = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // PRBS7, seed 7F: back-to-back stream and period
    mode = 3'd0; seed = 31'h7F; en = 1'b1; out_ready = 1'b1; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("t1_fill_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_w0", 32'(out_data), 32'b0000);
    cyc();
    chk("t1_w1", 32'(out_data), 32'b0010);
    ref_load(3'd0, 31'h7F);
    ref_word(exp_w);
    ref_word(exp_w);
    for (int k = 2; k <= 127; k++) begin
      cyc();
      ref_word(exp_w);
      chk("t1_stream", 32'(out_data), 32'(exp_w));
    end
    chk("t1_period", 32'(out_data), 32'b0000);

    // Mode change without load is ignored; then stall for 10 clk
    mode = 3'd3;
    cyc();
    ref_word(exp_w);
    chk("t2_mode_ignored", 32'(out_data), 32'(exp_w));
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t2_hold_data", 32'(out_data), 32'(exp_w));
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      ref_word(exp_w);
      chk("t2_resume", 32'(out_data), 32'(exp_w));
    end

    // PRBS15 with zero seed behaves like all-ones seed
    mode = 3'd2; seed = 31'h0; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("t3_load_valid", 32'(out_valid), 32'd0);
    ref_load(3'd2, 31'h7FFF);
    for (int k = 0; k < 8; k++) begin
      cyc();
      ref_word(exp_w);
      chk("t3_seed0", 32'(out_data), 32'(exp_w));
    end

    // Load during stall drops the pending word
    out_ready = 1'b0;
    cyc();
    chk("t4_stall_valid", 32'(out_valid), 32'd1);
    mode = 3'd0; seed = 31'h12; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("t4_dropped", 32'(out_valid), 32'd0);
    cyc();
    chk("t4_new_valid", 32'(out_valid), 32'd1);
    chk("t4_new_w0", 32'(out_data), 32'b0110);
    ref_load(3'd0, 31'h12);
    ref_word(exp_w);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      ref_word(exp_w);
      chk("t4_stream", 32'(out_data), 32'(exp_w));
    end

    // Halt: pending word transfers, then idle; re-enable continues
    en = 1'b0;
    cyc();
    chk("t5_valid_drop", 32'(out_valid), 32'd0);
    cyc();
    chk("t5_idle", 32'(out_valid), 32'd0);
    en = 1'b1;
    cyc();
    chk("t5_fill", 32'(out_valid), 32'd0);
    cyc();
    ref_word(exp_w);
    chk("t5_resume_valid", 32'(out_valid), 32'd1);
    chk("t5_resume_data", 32'(out_data), 32'(exp_w));

    // Mode 5 aliases to PRBS7
    mode = 3'd5; seed = 31'h7F; load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    chk("alias_w0", 32'(out_data), 32'b0000);
    cyc();
    chk("alias_w1", 32'(out_data), 32'b0010);

    // PRBS31 error injection
    mode = 3'd4; seed = 31'h7FFFFFFF; load = 1'b1;
    cyc();
    load = 1'b0;
    ref_load(3'd4, 31'h7FFFFFFF);
    cyc();
    ref_word(exp_w);
    chk("t6_w0", 32'(out_data), 32'(exp_w));
    err_inj = 1'b1;
    cyc();
    err_inj = 1'b0;
    ref_word(exp_w);
    chk("t6_pre", 32'(out_data), 32'(exp_w));
    cyc();
    ref_word(exp_w);
`ifdef PRBS_ERR_INJ_EN
    flip_w = exp_w ^ 4'b1000;
`else
    flip_w = exp_w;
`endif
    chk("t6_inject", 32'(out_data), 32'(flip_w));
    for (int k = 0; k < 4; k++) begin
      cyc();
      ref_word(exp_w);
      chk("t6_clean", 32'(out_data), 32'(exp_w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
